// File: rtl/sop_share_pkg.sv
// Shared definitions for the programmable shared-product SOP evaluator:
// configuration row layout, enable-row address and the abs_diff helper.
package sop_share_pkg;

  function automatic int pos_lsb();
    return 0;
  endfunction

  function automatic int neg_lsb(int n_in);
    return n_in;
  endfunction

  function automatic int act_lsb(int n_in);
    return 2 * n_in;
  endfunction

  function automatic int cfg_w(int n_in, int n_out);
    return 2 * n_in + n_out;
  endfunction

  // The enable row sits directly after the last product row.
  function automatic int en_row(int n_prod);
    return n_prod;
  endfunction

  function automatic logic [31:0] abs_diff(logic [31:0] a, logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sop_share_cfg.sv
// Shadow/active configuration register file; a write coinciding with a
// commit is folded into the copied image.
module sop_share_cfg
  import sop_share_pkg::*;
#(
  parameter int N_PROD = 6,
  parameter int AW     = 3,
  parameter int CW     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [CW-1:0]            cfg_data,
  input  logic                     cfg_commit,
  output logic [N_PROD:0][CW-1:0]  active
);

  logic [N_PROD:0][CW-1:0] shadow;
  logic [N_PROD:0][CW-1:0] shadow_nxt;

  // Addresses beyond the enable row match no row and are dropped.
  always_comb begin
    shadow_nxt = shadow;
    for (int unsigned r = 0; r <= N_PROD; r++) begin
      if (cfg_valid && cfg_addr == AW'(r)) shadow_nxt[r] = cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (cfg_commit) active <= shadow_nxt;
    end
  end

endmodule

// File: rtl/sop_share_eval.sv
// Two-stage programmable SOP evaluator with error monitor: stage 1 forms
// per-output product terms, stage 2 ORs them and compares with the exact result.
module sop_share_eval
  import sop_share_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int N_PROD = 6,
  parameter int ET     = 1,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid,
  input  logic [$clog2(N_PROD+1)-1:0]    cfg_addr,
  input  logic [2*N_IN+N_OUT-1:0]        cfg_data,
  input  logic                           cfg_commit,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_IN-1:0]                in_data,
  input  logic [N_OUT-1:0]               exact_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_OUT-1:0]               out_data,
  output logic                           out_err,
  input  logic                           stat_clr,
  output logic [CNT_W-1:0]               err_cnt,
  output logic [N_OUT-1:0]               err_max
);

  localparam int AW     = $clog2(N_PROD + 1);
  localparam int CW     = cfg_w(N_IN, N_OUT);
  localparam int PL     = pos_lsb();
  localparam int NL     = neg_lsb(N_IN);
  localparam int AL     = act_lsb(N_IN);
  localparam int EN_ROW = en_row(N_PROD);

  logic [N_PROD:0][CW-1:0]         active;
  logic [N_PROD-1:0]               pr;
  logic [N_OUT-1:0][N_PROD-1:0]    terms;
  logic                            s1_valid;
  logic [N_OUT-1:0][N_PROD-1:0]    s1_terms;
  logic [N_OUT-1:0]                s1_exact;
  logic [N_OUT-1:0]                approx;
  logic [31:0]                     diff_full;
  logic                            approx_err;
  logic [N_OUT-1:0]                s2_diff;
  logic                            s1_adv;
  logic                            s2_adv;

  sop_share_cfg #(
    .N_PROD (N_PROD),
    .AW     (AW),
    .CW     (CW)
  ) u_cfg (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .active     (active)
  );

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Empty products (no literal selected) are forced to 0 so unused rows are inert.
  always_comb begin
    pr    = '0;
    terms = '0;
    for (int unsigned p = 0; p < N_PROD; p++) begin
      pr[p] = (|(active[p][PL +: N_IN] | active[p][NL +: N_IN]))
            & (&((~active[p][PL +: N_IN] | in_data) & (~active[p][NL +: N_IN] | ~in_data)));
      for (int unsigned o = 0; o < N_OUT; o++) begin
        terms[o][p] = active[EN_ROW][o] & pr[p] & active[p][AL + int'(o)];
      end
    end
  end

  always_comb begin
    approx = '0;
    for (int unsigned o = 0; o < N_OUT; o++) approx[o] = |s1_terms[o];
    diff_full  = abs_diff(32'(approx), 32'(s1_exact));
    approx_err = diff_full > 32'(ET);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_terms  <= '0;
      s1_exact  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      s2_diff   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_terms <= terms;
          s1_exact <= exact_data;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= approx;
          out_err  <= approx_err;
          s2_diff  <= diff_full[N_OUT-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (stat_clr) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (out_valid && out_ready) begin
      if (out_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      if (s2_diff > err_max) err_max <= s2_diff;
    end
  end

endmodule

// File: doc/sop_share_eval.md
# sop_share_eval

Runtime-programmable shared-product sum-of-products evaluator with a built-in error monitor. It is the parametrised successor of the fixed, synthesis-time shared-logic SOP netlists produced by the approximation flow. Product literals, product-to-output activation and output enables are loaded through a configuration port instead of being baked into `assign`s. Sits after the candidate generator on the evaluation board: it streams input vectors through the programmed approximate circuit and checks each result against the exact circuit's output against an error threshold.

## Interface
- `N_IN`, 4: number of circuit inputs.
- `N_OUT`, 2: number of circuit outputs. Bit 0 is the output-word LSB.
- `N_PROD`, 6: number of shared product terms.
- `ET`, 1: error threshold; a beat violates when |approx − exact| > ET.
- `CNT_W`, 16: width of the violation counter.
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `cfg_valid`, in, 1: configuration write strobe.
- `cfg_addr`, in, clog2(N_PROD+1): row address. Rows 0..N_PROD-1 are product rows; row N_PROD is the output-enable row.
- `cfg_data`, in, 2*N_IN+N_OUT: row data.
  - Product row: [N_IN-1:0] positive-literal mask; [2N_IN-1:N_IN] negative-literal mask; [2N_IN+N_OUT-1:2N_IN] activation per output.
  - Enable row: [N_OUT-1:0] output enables.
- `cfg_commit`, in, 1: copy the shadow configuration into the active configuration.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: beat accepted when `in_valid && in_ready`.
- `in_data`, in, N_IN: input vector (`in_data[i]` is circuit input i).
- `exact_data`, in, N_OUT: exact-circuit output for the same beat.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accept.
- `out_data`, out, N_OUT: approximate output.
- `out_err`, out, 1: this beat violates ET.
- `stat_clr`, in, 1: clear statistics.
- `err_cnt`, out, CNT_W: saturating count of violating beats.
- `err_max`, out, N_OUT: maximum |approx − exact| seen since the last clear.

## Operation
- **Configuration storage.** Shadow and active copies. `cfg_valid` writes the shadow row; writes to addresses > N_PROD are ignored. `cfg_commit` copies shadow to active. A write in the same cycle as a commit is included in the copy.
- **Product evaluation.** pr[p] = AND over inputs i of (pos[i] ? x[i] : 1) & (neg[i] ? ~x[i] : 1).
  - A product with pos == neg == 0 evaluates to 0 (an empty product is disabled).
  - pos[i] == neg[i] == 1 yields 0.
- **Output composition.** out[o] = en[o] & OR over p of (pr[p] & act[p][o]).
- **Stage 1** (on accept): computes the per-output product bits from the ACTIVE configuration and registers them with `exact_data`. All configuration is consumed in stage 1, so a commit affects only beats accepted in later cycles. In-flight beats keep the old configuration.
- **Stage 2:** ORs the registered terms into `out_data`. It computes diff = |out_data − exact| as an unsigned N_OUT-bit magnitude and sets `out_err` = (diff > ET).
- **Statistics.** On each output handshake, `err_cnt` increments if `out_err` (it saturates at 2^CNT_W−1) and `err_max` = max(`err_max`, diff).
  - `stat_clr` zeroes both counters. A handshake in the same cycle is discarded.
- **Reset (async).** Clears both configuration copies, both pipeline valids and all statistics, so every output reads 0 and `in_ready` = 1.
  - A reset mid-stream drops in-flight beats; no partial output is produced.

## Timing
- Latency is 2 cycles from input handshake to `out_valid` when there is no backpressure. Throughput is 1 beat/cycle.
- Standard valid/ready pipeline. A stage advances when it is empty or its successor advances.
- `in_ready` = !s1_valid || !s2_valid || out_ready; it is combinational only from `out_ready`.
- While `out_valid && !out_ready`: `out_data`, `out_err` and the statistics are held stable.
- Commit is single-cycle; `cfg_valid` and `cfg_commit` are never stalled.

## Structure
- Shared package `sop_share_pkg` holds:
  - the cfg field offsets and widths as functions of N_IN/N_OUT;
  - the enable-row address constant;
  - the `abs_diff` function, which is reused by the abs_diff benchmark benches.
- One sub-module, `sop_share_cfg`, contains the shadow/active register file with write, commit and reset. The top level contains the two-stage datapath and the statistics.

## Test plan
The parameters of the first four scenarios are N_IN=4, N_OUT=2, N_PROD=6 and ET=1.
- **Reset, default config:** after reset, drive in=4'b1000 and exact=0 → out_data=0, out_err=0, err_cnt=0.
- **Single product, both outputs:**
  - Program row0 pos=4'b1000, neg=4'b0011, act=2'b11; enable row=2'b11; commit.
  - in=4'b1000 → out_data=2'b11 at 2 cycles.
  - in=4'b1001 → 2'b00.
- **Error statistics:** with that configuration:
  - in=4'b1000, exact=2'b00 → diff 3, out_err=1, err_cnt=1, err_max=3.
  - Then exact=2'b10 → diff 1, out_err=0, err_cnt stays 1.
- **Commit boundary:** stream beats each cycle. Commit the act change row0 act=2'b01 in cycle k. Beats accepted ≤k give 2'b11; beats accepted >k give 2'b01.
- **Backpressure:** hold out_ready=0 for 5 cycles with in_valid=1. Exactly 2 beats are buffered and in_ready=0. Results are delivered in order with no loss or duplication, and err_cnt advances only on handshakes.
- **Corner cases:**
  - Write to address 7 is ignored.
  - pos=neg on a bit makes the product constant 0.
  - err_cnt saturates with CNT_W=2 after 3 violations.
  - Reset asserted with both stages full gives out_valid=0 on the next cycle.
